// File: rtl/subleq_fetch.sv
// Subleq instruction fetch/decode stage: PC-driven ROM fetch, field slicing, valid/ready hand-off.
// Optional illegal-opcode trap enabled by defining FETCH_ILLEGAL_TRAP_EN.
module subleq_fetch #(
    parameter int unsigned P_ADDR = 8,
    parameter int unsigned P_MEM  = 256,
    parameter int unsigned P_DATA = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [P_ADDR-1:0] rom_addr,
    input  logic [P_DATA-1:0] rom_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [2:0]        ins_op,
    output logic [7:0]        ins_a,
    output logic [7:0]        ins_b,
    output logic [7:0]        ins_c,
    output logic [P_ADDR-1:0] ins_pc,
    input  logic              br_valid,
    input  logic [P_ADDR-1:0] br_target,
    output logic              halted
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    localparam logic [P_ADDR-1:0] LastPc = P_ADDR'(P_MEM - 1);
    localparam logic [P_ADDR:0]   MemTop = (P_ADDR + 1)'(P_MEM);

    state_e              state_q;
    logic [P_ADDR-1:0]   pc_q;
    logic [P_DATA-1:0]   word_q;
    logic [P_ADDR-1:0]   ins_pc_q;
    logic                valid_q;
    logic                halted_q;

    logic [P_ADDR-1:0]   pc_inc;
    logic [P_ADDR-1:0]   br_pc;
    logic                advance;
    logic                illegal;

    always_comb begin
        pc_inc  = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
        // Out-of-range redirect targets fold back to address 0.
        br_pc   = ({1'b0, br_target} >= MemTop) ? '0 : br_target;
        advance = !valid_q || ins_ready;
        illegal = (rom_data[26:24] == 3'b011) ||
                  (rom_data[26] && (rom_data[25:24] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            word_q   <= '0;
            ins_pc_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (br_valid) pc_q <= br_pc;
                    state_q <= StRun;
                end
                StRun: begin
                    if (br_valid) begin
                        valid_q <= 1'b0;
                        pc_q    <= br_pc;
                    end else if (advance) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
                        if (illegal) begin
                            // PC stays on the offending word so it remains visible on rom_addr.
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= StHalt;
                        end else begin
                            word_q   <= rom_data;
                            ins_pc_q <= pc_q;
                            valid_q  <= 1'b1;
                            pc_q     <= pc_inc;
                        end
`else
                        word_q   <= rom_data;
                        ins_pc_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_inc;
`endif
                    end
                end
                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign rom_addr  = pc_q;
    assign ins_valid = valid_q;
    assign ins_op    = word_q[26:24];
    assign ins_a     = word_q[23:16];
    assign ins_b     = word_q[15:8];
    assign ins_c     = word_q[7:0];
    assign ins_pc    = ins_pc_q;

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
    logic unused_trap;
    assign unused_trap = halted_q ^ illegal;
`endif

endmodule

// File: doc/subleq_fetch.md
# subleq_fetch

Instruction fetch and decode stage sitting directly downstream of the instruction ROM in the Subleq core. Drives the ROM address from its program counter and captures the 27-bit instruction word. Splits the word into opcode and A/B/C operand fields and hands it to the execute stage over a valid/ready handshake. Accepts branch redirects from execute and flushes the instruction currently held.

## Interface
- P_ADDR, 8: ROM address width, also the PC width.
- P_MEM, 256: number of ROM words. The PC wraps to 0 after P_MEM-1.
- P_DATA, 27: instruction width. Fixed layout: [26:24] op, [23:16] A, [15:8] B, [7:0] C.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  P_ADDR  ROM address, equal to the PC register (no combinational path from inputs).
- rom_data  in  P_DATA  combinational ROM read data for rom_addr.
- ins_valid  out  1  instruction register holds a valid instruction.
- ins_ready  in  1  execute accepts the instruction this cycle.
- ins_op  out  3  opcode: 000 SUBLEQ, 001 EXR, 010 EXW, 100 IMM.
- ins_a, ins_b, ins_c  out  8 each  operand fields.
- ins_pc  out  P_ADDR  address the held instruction was fetched from.
- br_valid  in  1  redirect request from execute.
- br_target  in  P_ADDR  redirect address.
- halted  out  1  fetch is stopped on an illegal opcode. Tied 0 unless the trap is enabled.

## Operation
- States are IDLE, RUN and HALT. HALT is only reachable with the trap macro enabled.
- IDLE: entered on reset. Performs no fetch. Moves to RUN on the first clock edge after rst_n deasserts.
- RUN advance condition: the instruction register is empty (ins_valid=0) or is being consumed (ins_ready=1).
- When the advance condition holds in RUN:
  - Load rom_data into the instruction register and set ins_pc to the PC.
  - Set ins_valid to 1.
  - PC becomes PC+1, or 0 if PC = P_MEM-1.
- Stall: when ins_valid=1 and ins_ready=0, the PC and all ins_* outputs hold unchanged.
- Redirect: br_valid=1 in any non-HALT state has priority over advance and over stall.
  - ins_valid goes to 0 next cycle; a concurrent ins_ready handshake still counts as accepted.
  - The PC becomes br_target, or 0 if br_target ≥ P_MEM.
  - The next fetch occurs on the following edge.
- A redirect during IDLE updates the PC; the state still goes to RUN.
- Decode is pure field slicing of the registered word. Operands are passed unsigned and unmodified.

## Timing
- Reset values:
  - state IDLE, PC 0, rom_addr 0;
  - ins_valid 0, ins_op/ins_a/ins_b/ins_c 0, ins_pc 0;
  - halted 0.
- Reset is asynchronous: asserting rst_n mid-stream clears everything immediately, whatever the state.
- Latency from reset release: ins_valid first rises after the second rising edge. The instruction delivered is ROM[0].
- Throughput: one instruction per cycle while ins_ready=1.
- Redirect penalty: exactly one bubble. ins_valid=0 for one cycle, then ROM[br_target] is presented.
- No output depends combinationally on an input.

## Configuration
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 011, 101, 110 and 111 are illegal.
  - When an illegal word would be loaded, the instruction register is not loaded and ins_valid goes to 0.
  - The PC holds at the offending address, halted goes to 1 and the state becomes HALT.
  - HALT ignores br_valid; only reset exits it.
- Undefined: every opcode is delivered unchanged, HALT does not exist and halted is constant 0.

## Test plan
- Reset release with ROM[0]=100_00000000_01000001_00000001 -> after 2 edges: ins_valid=1, op=100, a=0, b=0x41, c=1, ins_pc=0.
- ins_ready held 1 over ROM[0..3] -> ops 100, 001, 010, 000 on consecutive cycles, ins_pc 0..3. ROM[1] gives a=4, c=2.
- Hold ins_ready=0 for 3 cycles at ins_pc=1 -> all outputs stable and rom_addr=2; release -> ins_pc=2 next cycle.
- br_valid=1, br_target=3 while stalled -> next cycle ins_valid=0, then ins_pc=3, op=000, c=3.
- P_MEM=16 and ready held 1 -> ins_pc goes 15 then 0. br_target=20 -> next delivered ins_pc=0.
- With FETCH_ILLEGAL_TRAP_EN and ROM[2] op=111 -> after ins_pc=1 is consumed: halted=1, ins_valid=0 and rom_addr=2 permanently. br_valid has no effect; rst_n low clears halted.
